// File: rtl/alu_pkg.sv
// Shared op codes, widths and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'd2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'd3;
  localparam logic [OP_W-1:0] ALU_SHR  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SHRA = 4'd5;
  localparam logic [OP_W-1:0] ALU_SHL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_ROR  = 4'd7;
  localparam logic [OP_W-1:0] ALU_ROL  = 4'd8;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd9;
  localparam logic [OP_W-1:0] ALU_DIV  = 4'd10;
  localparam logic [OP_W-1:0] ALU_NEG  = 4'd11;
  localparam logic [OP_W-1:0] ALU_NOT  = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_unit_if.sv
// Bus-side handshake and result signals of the sequential ALU.
interface seq_alu_unit_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] BusIn;
  logic             Yin;
  logic             Start;
  logic [OP_W-1:0]  Op;
  logic [WIDTH-1:0] ZHi;
  logic [WIDTH-1:0] ZLo;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output BusIn, Yin, Start, Op,
    input  ZHi, ZLo, Busy, Done, DivByZero
  );

  modport slave (
    input  BusIn, Yin, Start, Op,
    output ZHi, ZLo, Busy, Done, DivByZero
  );

endinterface

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring, on magnitudes).
// result_hi/result_lo present the value after the current step, sign-corrected,
// so the owner can capture it on the edge where last is high.
module seq_muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  // acc carries one guard bit so Booth subtract of the most-negative
  // multiplicand and the restoring trial subtract never overflow.
  logic [WIDTH:0]   acc_q, acc_n, m_q, sum, r_sh, trial;
  logic [WIDTH-1:0] q_q, q_n, a_mag, b_mag;
  logic             qm1_q, qm1_n;
  logic             div_q, neg_quo_q, neg_rem_q;
  logic [CW-1:0]    cnt_q;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = (cnt_q == CW'(1));

  // One iteration of the selected algorithm plus the final sign fix-up.
  always_comb begin
    acc_n = acc_q;
    q_n   = q_q;
    qm1_n = qm1_q;
    sum   = acc_q;
    r_sh  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial = r_sh - m_q;
    if (div_q) begin
      if (trial[WIDTH]) begin
        acc_n = r_sh;
        q_n   = {q_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = trial;
        q_n   = {q_q[WIDTH-2:0], 1'b1};
      end
      result_lo = neg_quo_q ? -q_n : q_n;
      result_hi = neg_rem_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    end else begin
      case ({q_q[0], qm1_q})
        2'b01:   sum = acc_q + m_q;
        2'b10:   sum = acc_q - m_q;
        default: sum = acc_q;
      endcase
      acc_n     = {sum[WIDTH], sum[WIDTH:1]};
      q_n       = {sum[0], q_q[WIDTH-1:1]};
      qm1_n     = q_q[0];
      result_hi = acc_n[WIDTH-1:0];
      result_lo = q_n;
    end
  end

  // Operand latch on go, iteration registers and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (go) begin
      acc_q     <= '0;
      qm1_q     <= 1'b0;
      div_q     <= is_div;
      cnt_q     <= CW'(WIDTH);
      neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_q <= a[WIDTH-1];
      if (is_div) begin
        q_q <= a_mag;
        m_q <= {1'b0, b_mag};
      end else begin
        q_q <= a;
        m_q <= {b[WIDTH-1], b};
      end
    end else if (step) begin
      acc_q <= acc_n;
      q_q   <= q_n;
      qm1_q <= qm1_n;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// Sequential ALU: Y/Z registers, single-cycle ops and Start/Busy/Done control
// around the iterative multiply/divide core.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           Clock,
  input  logic           Clear,
  seq_alu_unit_if.slave  bus
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned SHW1 = SHW + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, z_hi_q, z_lo_q, z_hi_d, z_lo_d;
  logic             done_q, done_d, dbz_q, dbz_d, z_we;
  logic             core_go, core_step, core_last, is_div, multi;
  logic [WIDTH-1:0] core_hi, core_lo, a, b, sc_hi, sc_lo;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     inv_sh;

  assign a      = y_q;
  assign b      = bus.BusIn;
  assign sh     = b[SHW-1:0];
  assign inv_sh = SHW1'(WIDTH) - {1'b0, sh};
  assign is_div = (bus.Op == ALU_DIV);
  assign multi  = (bus.Op == ALU_MUL) || (is_div && (b != '0));

  // Single-cycle results, including the divide-by-zero shortcut.
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    sc_hi = '0;
    sc_lo = '0;
    case (bus.Op)
      ALU_ADD:  begin sc_lo = add_w[WIDTH-1:0]; sc_hi = WIDTH'(add_w[WIDTH]); end
      ALU_SUB:  begin sc_lo = sub_w[WIDTH-1:0]; sc_hi = WIDTH'(sub_w[WIDTH]); end
      ALU_AND:  sc_lo = a & b;
      ALU_OR:   sc_lo = a | b;
      ALU_SHR:  sc_lo = a >> sh;
      ALU_SHRA: sc_lo = $signed(a) >>> sh;
      ALU_SHL:  sc_lo = a << sh;
      ALU_ROR:  sc_lo = (a >> sh) | (a << inv_sh);
      ALU_ROL:  sc_lo = (a << sh) | (a >> inv_sh);
      ALU_DIV:  begin sc_lo = '1; sc_hi = a; end
      ALU_NEG:  sc_lo = -b;
      ALU_NOT:  sc_lo = ~b;
      default:  begin sc_lo = '0; sc_hi = '0; end
    endcase
  end

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (Clock),
    .rst       (Clear),
    .go        (core_go),
    .is_div    (is_div),
    .a         (a),
    .b         (b),
    .step      (core_step),
    .result_hi (core_hi),
    .result_lo (core_lo),
    .last      (core_last)
  );

  // Next state, Z write select and handshake pulses.
  always_comb begin
    state_d   = state_q;
    core_go   = 1'b0;
    core_step = 1'b0;
    z_we      = 1'b0;
    z_hi_d    = sc_hi;
    z_lo_d    = sc_lo;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          dbz_d = 1'b0;
          if (multi) begin
            core_go = 1'b1;
            state_d = ST_RUN;
          end else begin
            z_we   = 1'b1;
            done_d = 1'b1;
            dbz_d  = is_div;
          end
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          z_we    = 1'b1;
          z_hi_d  = core_hi;
          z_lo_d  = core_lo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers; Clear overrides everything.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      if (bus.Yin) y_q <= b;
      if (z_we) begin
        z_hi_q <= z_hi_d;
        z_lo_q <= z_lo_d;
      end
    end
  end

  assign bus.ZHi       = z_hi_q;
  assign bus.ZLo       = z_lo_q;
  assign bus.Busy      = (state_q == ST_RUN);
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// Directed scoreboard bench for seq_alu_unit at WIDTH=32.
module tb_seq_alu_unit;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic clr;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  logic [31:0] y_model;

  seq_alu_unit_if #(.WIDTH(32)) bus_if ();

  seq_alu_unit #(.WIDTH(32)) dut (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference behaviour written from the op definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] w;
    logic signed [63:0] sa, sbv, p;
    logic [31:0] r;
    int n;
    e = '0;
    n = int'(b[4:0]);
    sa = 64'(signed'(a));
    sbv = 64'(signed'(b));
    case (op)
      ALU_ADD:  begin w = {32'b0, a} + {32'b0, b}; e.lo = w[31:0]; e.hi = {31'b0, w[32]}; end
      ALU_SUB:  begin e.lo = a - b; e.hi = (a < b) ? 32'd1 : 32'd0; end
      ALU_AND:  e.lo = a & b;
      ALU_OR:   e.lo = a | b;
      ALU_SHR:  e.lo = a >> n;
      ALU_SHRA: e.lo = $signed(a) >>> n;
      ALU_SHL:  e.lo = a << n;
      ALU_ROR:  begin r = a; for (int i = 0; i < n; i++) r = {r[0], r[31:1]}; e.lo = r; end
      ALU_ROL:  begin r = a; for (int i = 0; i < n; i++) r = {r[30:0], r[31]}; e.lo = r; end
      ALU_MUL:  begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
      ALU_DIV: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
        end else begin
          p = sa / sbv; e.lo = p[31:0];
          p = sa % sbv; e.hi = p[31:0];
        end
      end
      ALU_NEG:  e.lo = 32'd0 - b;
      ALU_NOT:  e.lo = ~b;
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic load_y(input logic [31:0] v);
    bus_if.BusIn = v;
    bus_if.Yin   = 1'b1;
    @(posedge clk); #1;
    bus_if.Yin   = 1'b0;
    y_model      = v;
  endtask

  // Issue one op, optionally with Yin in the Start cycle or with Start/Yin pokes while busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] b,
                        input bit with_yin, input bit poke);
    exp_t e;
    int edges, busy_n, want_lat;
    bit seen;
    sb.push_back(model(op, y_model, b));
    want_lat = (op == ALU_MUL || (op == ALU_DIV && b != 32'd0)) ? 32 : 0;
    bus_if.Op    = op;
    bus_if.BusIn = b;
    bus_if.Start = 1'b1;
    bus_if.Yin   = with_yin;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    bus_if.Yin   = 1'b0;
    if (with_yin) y_model = b;
    edges = 0; busy_n = 0; seen = 1'b0;
    while (edges < 100 && !seen) begin
      if (bus_if.Done) seen = 1'b1;
      else begin
        if (bus_if.Busy) busy_n++;
        if (poke) begin
          if (edges == 5) begin bus_if.Start = 1'b1; bus_if.Op = ALU_ADD; bus_if.BusIn = 32'h99; end
          else if (edges == 6) bus_if.Start = 1'b0;
          else if (edges == 8) begin bus_if.Yin = 1'b1; bus_if.BusIn = 32'h55; end
          else if (edges == 9) begin bus_if.Yin = 1'b0; y_model = 32'h55; end
        end
        @(posedge clk); #1;
        edges++;
      end
    end
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    e = sb.pop_front();
    check({tag, ".lo"}, 64'(bus_if.ZLo), 64'(e.lo));
    check({tag, ".hi"}, 64'(bus_if.ZHi), 64'(e.hi));
    check({tag, ".dbz"}, 64'(bus_if.DivByZero), 64'(e.dbz));
    check({tag, ".latency"}, 64'(edges), 64'(want_lat));
    check({tag, ".busy_cycles"}, 64'(busy_n), 64'(want_lat));
    check({tag, ".busy_at_done"}, 64'(bus_if.Busy), 64'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 64'(bus_if.Done), 64'd0);
  endtask

  initial begin
    int done_n;
    bus_if.BusIn = '0;
    bus_if.Yin   = 1'b0;
    bus_if.Start = 1'b0;
    bus_if.Op    = ALU_ADD;
    y_model      = '0;
    clr          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.zhi", 64'(bus_if.ZHi), 64'd0);
    check("rst.zlo", 64'(bus_if.ZLo), 64'd0);
    check("rst.busy", 64'(bus_if.Busy), 64'd0);
    check("rst.done", 64'(bus_if.Done), 64'd0);
    check("rst.dbz", 64'(bus_if.DivByZero), 64'd0);
    clr = 1'b0;

    load_y(32'h0000_000F);  run_op("add", ALU_ADD, 32'h3, 1'b0, 1'b0);
    load_y(32'hFFFF_FFFF);  run_op("add_carry", ALU_ADD, 32'h1, 1'b0, 1'b0);
    load_y(32'h0000_0005);  run_op("sub_borrow", ALU_SUB, 32'h7, 1'b0, 1'b0);
    load_y(32'h8000_0001);  run_op("ror1", ALU_ROR, 32'h1, 1'b0, 1'b0);
                            run_op("rol4", ALU_ROL, 32'h4, 1'b0, 1'b0);
    load_y(32'h8000_00F0);  run_op("shra4", ALU_SHRA, 32'h4, 1'b0, 1'b0);
                            run_op("shr4", ALU_SHR, 32'h4, 1'b0, 1'b0);
                            run_op("shl_amt0", ALU_SHL, 32'h20, 1'b0, 1'b0);
                            run_op("ror31", ALU_ROR, 32'h1F, 1'b0, 1'b0);
    load_y(32'hF0F0_1234);  run_op("and", ALU_AND, 32'h0FF0_FF00, 1'b0, 1'b0);
                            run_op("or", ALU_OR, 32'h0FF0_FF00, 1'b0, 1'b0);
                            run_op("not", ALU_NOT, 32'h0FF0_FF00, 1'b0, 1'b0);
                            run_op("neg", ALU_NEG, 32'h0000_0001, 1'b0, 1'b0);
                            run_op("rsvd", 4'd14, 32'h1234_5678, 1'b0, 1'b0);

    load_y(32'hFFFF_FFFD);  run_op("mul_neg3x7", ALU_MUL, 32'h7, 1'b0, 1'b1);
    load_y(32'h8000_0000);  run_op("mul_minxmin", ALU_MUL, 32'h8000_0000, 1'b0, 1'b0);
                            run_op("mul_minxm1", ALU_MUL, 32'hFFFF_FFFF, 1'b0, 1'b0);
    load_y(32'hFFFF_FFEF);  run_op("div_m17by5", ALU_DIV, 32'h5, 1'b0, 1'b0);
    load_y(32'h8000_0000);  run_op("div_minbym1", ALU_DIV, 32'hFFFF_FFFF, 1'b0, 1'b0);
    load_y(32'h0000_0064);  run_op("div_100bym7", ALU_DIV, 32'hFFFF_FFF9, 1'b0, 1'b0);

    load_y(32'h0000_1234);  run_op("div_by0", ALU_DIV, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("dbz.sticky", 64'(bus_if.DivByZero), 64'd1);
    check("z.hold", 64'(bus_if.ZLo), 64'hFFFF_FFFF);
    run_op("add_clr_dbz", ALU_ADD, 32'h1, 1'b0, 1'b0);

    load_y(32'd10);         run_op("add_yin_same", ALU_ADD, 32'd3, 1'b1, 1'b0);
                            run_op("add_new_y", ALU_ADD, 32'd1, 1'b0, 1'b0);

    // Clear in the middle of a multiply.
    load_y(32'd5);
    bus_if.Op    = ALU_MUL;
    bus_if.BusIn = 32'd7;
    bus_if.Start = 1'b1;
    @(posedge clk); #1;
    bus_if.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    y_model = '0;
    check("clr.busy", 64'(bus_if.Busy), 64'd0);
    check("clr.zhi", 64'(bus_if.ZHi), 64'd0);
    check("clr.zlo", 64'(bus_if.ZLo), 64'd0);
    check("clr.done", 64'(bus_if.Done), 64'd0);
    run_op("add_after_clr", ALU_ADD, 32'd5, 1'b0, 1'b0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.Done) done_n++;
    end
    check("clr.no_stray_done", 64'(done_n), 64'd0);
    check("sb.empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
